// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : battle_pkg
//  Purpose  : Shared types for the battle turn scheduler: phase encoding
//             (doubles as the state_out code seen by the renderer) and the
//             menu choice encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package battle_pkg;

    typedef enum logic [3:0] {
        PH_MENU   = 4'b0000,
        PH_PLAYER = 4'b0001,
        PH_ENEMY  = 4'b1000,
        PH_LOSE   = 4'b0010,
        PH_WIN    = 4'b0100,
        PH_IDLE   = 4'b1111
    } phase_t;

    localparam logic [1:0] c_CHOICE_FIGHT = 2'b00;
    localparam logic [1:0] c_CHOICE_HEAL  = 2'b01;

    // Phase that follows a menu selection; unknown codes behave as FIGHT.
    function automatic phase_t menu_next(input logic [1:0] choice);
        phase_t p;
        case (choice)
            c_CHOICE_FIGHT: p = PH_PLAYER;
            c_CHOICE_HEAL:  p = PH_ENEMY;
            default:        p = PH_PLAYER;
        endcase
        return p;
    endfunction

    function automatic logic is_terminal(input phase_t p);
        return (p == PH_WIN) || (p == PH_LOSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/battle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : battle_sequencer_if
//  Purpose  : Bundles the phase-module handshakes and the status outputs of
//             the battle sequencer.
//  Modports : slave  - the sequencer (consumes *_in, drives *_out)
//             master - the game-side environment (drives *_in)
//  Revision : 1.0 - initial release
// ============================================================================
interface battle_sequencer_if;
    logic       new_frame_in;
    logic       menu_done_in;
    logic [1:0] menu_choice_in;
    logic       player_done_in;
    logic [7:0] player_dmg_in;
    logic       enemy_done_in;
    logic       enemy_hit_in;
    logic       restart_in;

    logic [3:0] state_out;
    logic       phase_start_out;
    logic       round_rst_out;
    logic [7:0] player_hp_out;
    logic [7:0] enemy_hp_out;
    logic [7:0] round_count_out;
    logic       game_over_out;
    logic       win_out;

    modport slave (
        input  new_frame_in, menu_done_in, menu_choice_in, player_done_in,
               player_dmg_in, enemy_done_in, enemy_hit_in, restart_in,
        output state_out, phase_start_out, round_rst_out, player_hp_out,
               enemy_hp_out, round_count_out, game_over_out, win_out
    );

    modport master (
        output new_frame_in, menu_done_in, menu_choice_in, player_done_in,
               player_dmg_in, enemy_done_in, enemy_hit_in, restart_in,
        input  state_out, phase_start_out, round_rst_out, player_hp_out,
               enemy_hp_out, round_count_out, game_over_out, win_out
    );
endinterface
`default_nettype wire

// File: rtl/hp_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hp_counter
//  Purpose  : 8-bit hit-point register. Add saturates at MAX, subtract floors
//             at 0, load restores MAX. Priority: load > add > sub.
//  Ports    : clk, rst_n (async, active low, resets to MAX)
//             i_load, i_add, i_sub - operation strobes
//             i_amount             - operand for add/sub
//             o_value              - current HP (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module hp_counter #(
    parameter int unsigned MAX = 255
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_load,
    input  wire logic       i_add,
    input  wire logic       i_sub,
    input  wire logic [7:0] i_amount,
    output logic      [7:0] o_value
);
    localparam logic [8:0] c_MAX = 9'(MAX);

    logic [7:0] r_value;
    logic [8:0] w_sum_raw;
    logic [7:0] w_sum_sat;
    logic [7:0] w_diff_sat;

    always_comb begin
        w_sum_raw  = {1'b0, r_value} + {1'b0, i_amount};
        w_sum_sat  = (w_sum_raw > c_MAX) ? c_MAX[7:0] : w_sum_raw[7:0];
        w_diff_sat = (r_value > i_amount) ? (r_value - i_amount) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= c_MAX[7:0];
        end else if (i_load) begin
            r_value <= c_MAX[7:0];
        end else if (i_add) begin
            r_value <= w_sum_sat;
        end else if (i_sub) begin
            r_value <= w_diff_sat;
        end
    end

    assign o_value = r_value;
endmodule
`default_nettype wire

// File: rtl/battle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : battle_sequencer
//  Purpose  : Turn scheduler for the battle screen. Walks MENU -> PLAYER ->
//             ENEMY (or MENU -> ENEMY on HEAL), tracks both HP values and the
//             round count, and decides WIN/LOSE. Every phase change is held
//             pending and committed on the next frame start so the renderer
//             never changes source mid-frame.
//  Ports    : clk, rst_n (async, active low)
//             bus (slave) - phase handshakes in, phase/HP/status out
//  Revision : 1.0 - initial release
// ============================================================================
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int unsigned PLAYER_HP_MAX        = 20,
    parameter int unsigned ENEMY_HP_MAX         = 100,
    parameter int unsigned HIT_DAMAGE           = 4,
    parameter int unsigned HEAL_AMOUNT          = 8,
    parameter int unsigned ENEMY_TIMEOUT_FRAMES = 600
) (
    input wire logic           clk,
    input wire logic           rst_n,
    battle_sequencer_if.slave  bus
);
    localparam int          c_TW      = $clog2(ENEMY_TIMEOUT_FRAMES + 1);
    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(ENEMY_TIMEOUT_FRAMES);
    localparam logic [7:0]  c_HIT     = 8'(HIT_DAMAGE);
    localparam logic [7:0]  c_HEAL    = 8'(HEAL_AMOUNT);

    phase_t          r_phase;
    phase_t          r_next_phase;
    logic            r_pending;
    logic [c_TW-1:0] r_timeout;
    logic [7:0]      r_round;
    logic            r_menu_q;
    logic            r_player_q;
    logic            r_enemy_q;
    logic            r_phase_start;
    logic            r_round_rst;
    logic            r_game_over;
    logic            r_win;

    logic [7:0] w_player_hp;
    logic [7:0] w_enemy_hp;
    logic       w_menu_evt;
    logic       w_player_evt;
    logic       w_enemy_active;
    logic       w_hit;
    logic       w_fatal;
    logic       w_enemy_exit;
    logic       w_heal;
    logic       w_restart;
    logic       w_commit;
    logic [7:0] w_player_amt;

    // Events only count in their own phase and only until a request is
    // pending; hits additionally stop once an ENEMY exit is pending.
    always_comb begin
        w_menu_evt     = bus.menu_done_in & ~r_menu_q &
                         (r_phase == PH_MENU) & ~r_pending;
        w_player_evt   = bus.player_done_in & ~r_player_q &
                         (r_phase == PH_PLAYER) & ~r_pending;
        w_enemy_active = (r_phase == PH_ENEMY) & ~r_pending;
        w_hit          = w_enemy_active & bus.enemy_hit_in;
        w_fatal        = w_hit & (w_player_hp <= c_HIT);
        w_enemy_exit   = w_enemy_active &
                         ((bus.enemy_done_in & ~r_enemy_q) | (r_timeout == c_TIMEOUT));
        w_heal         = w_menu_evt & (bus.menu_choice_in == c_CHOICE_HEAL);
        w_restart      = bus.restart_in & is_terminal(r_phase);
        // r_pending is registered, so a frame in the event cycle cannot commit.
        w_commit       = r_pending & bus.new_frame_in;
        w_player_amt   = w_heal ? c_HEAL : c_HIT;
    end

    hp_counter #(.MAX(PLAYER_HP_MAX)) u_player_hp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_restart),
        .i_add    (w_heal),
        .i_sub    (w_hit),
        .i_amount (w_player_amt),
        .o_value  (w_player_hp)
    );

    hp_counter #(.MAX(ENEMY_HP_MAX)) u_enemy_hp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_restart),
        .i_add    (1'b0),
        .i_sub    (w_player_evt),
        .i_amount (bus.player_dmg_in),
        .o_value  (w_enemy_hp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase       <= PH_IDLE;
            r_next_phase  <= PH_IDLE;
            r_pending     <= 1'b0;
            r_timeout     <= '0;
            r_round       <= 8'd0;
            r_menu_q      <= 1'b0;
            r_player_q    <= 1'b0;
            r_enemy_q     <= 1'b0;
            r_phase_start <= 1'b0;
            r_round_rst   <= 1'b0;
            r_game_over   <= 1'b0;
            r_win         <= 1'b0;
        end else begin
            r_menu_q      <= bus.menu_done_in;
            r_player_q    <= bus.player_done_in;
            r_enemy_q     <= bus.enemy_done_in;
            r_phase_start <= 1'b0;
            r_round_rst   <= 1'b0;

            // Frames spent in the committed ENEMY phase; cleared on leaving.
            if ((r_phase == PH_ENEMY) && !w_commit) begin
                if (bus.new_frame_in && (r_timeout < c_TIMEOUT)) begin
                    r_timeout <= r_timeout + 1'b1;
                end
            end else begin
                r_timeout <= '0;
            end

            case (r_phase)
                PH_IDLE: begin
                    if (bus.new_frame_in) begin
                        r_phase       <= PH_MENU;
                        r_phase_start <= 1'b1;
                    end
                end
                PH_WIN, PH_LOSE: begin
                    if (w_restart) begin
                        r_phase     <= PH_IDLE;
                        r_round     <= 8'd0;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                    end
                end
                default: begin
                    if (w_commit) begin
                        r_phase       <= r_next_phase;
                        r_pending     <= 1'b0;
                        r_phase_start <= 1'b1;
                        r_game_over   <= is_terminal(r_next_phase);
                        r_win         <= (r_next_phase == PH_WIN);
                        if ((r_phase == PH_ENEMY) && (r_next_phase == PH_MENU)) begin
                            r_round_rst <= 1'b1;
                            if (r_round != 8'hFF) begin
                                r_round <= r_round + 8'd1;
                            end
                        end
                    end else if (w_menu_evt) begin
                        r_pending    <= 1'b1;
                        r_next_phase <= menu_next(bus.menu_choice_in);
                    end else if (w_player_evt) begin
                        r_pending <= 1'b1;
                        if (w_enemy_hp <= bus.player_dmg_in) begin
                            r_next_phase <= PH_WIN;
                        end else begin
                            r_next_phase <= PH_ENEMY;
                        end
                    end else if (w_fatal) begin
                        // A killing hit wins over a same-cycle done/timeout.
                        r_pending    <= 1'b1;
                        r_next_phase <= PH_LOSE;
                    end else if (w_enemy_exit) begin
                        r_pending    <= 1'b1;
                        r_next_phase <= PH_MENU;
                    end
                end
            endcase
        end
    end

    assign bus.state_out       = r_phase;
    assign bus.phase_start_out = r_phase_start;
    assign bus.round_rst_out   = r_round_rst;
    assign bus.player_hp_out   = w_player_hp;
    assign bus.enemy_hp_out    = w_enemy_hp;
    assign bus.round_count_out = r_round;
    assign bus.game_over_out   = r_game_over;
    assign bus.win_out         = r_win;
endmodule
`default_nettype wire

// File: doc/battle_sequencer.md
Name: battle_sequencer

Overview:
- Turn scheduler for the battle screen. Sequences the menu, player and enemy phase modules through start/done handshakes.
- Owns player and enemy HP and the round counter, and decides win/lose.
- All phase changes are committed only on a frame boundary, so the renderer never switches source mid-frame.
- Sits between the phase modules and the pixel mux / health bar in the top-level game state.

Parameters:
- PLAYER_HP_MAX, 20, player HP at reset/restart (≤255)
- ENEMY_HP_MAX, 100, enemy HP at reset/restart (≤255)
- HIT_DAMAGE, 4, player HP lost per enemy_hit_in pulse
- HEAL_AMOUNT, 8, player HP restored by the HEAL menu choice
- ENEMY_TIMEOUT_FRAMES, 600, frames after which the enemy phase ends without enemy_done_in

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- new_frame_in  in  1  one-cycle pulse at frame start (hcount=0, vcount=0)
- menu_done_in  in  1  menu finished (level; rising edge is the event)
- menu_choice_in  in  2  menu selection, sampled on the menu_done rising edge: 00 FIGHT, 01 HEAL, others treated as FIGHT
- player_done_in  in  1  player attack finished (level; rising edge is the event)
- player_dmg_in  in  8  attack damage, sampled on the player_done rising edge
- enemy_done_in  in  1  enemy attack pattern finished (level; rising edge is the event)
- enemy_hit_in  in  1  one-cycle pulse per bullet collision
- restart_in  in  1  one-cycle pulse; leaves WIN/LOSE
- state_out  out  4  phase code: MENU 0000, PLAYER 0001, ENEMY 1000, LOSE 0010, WIN 0100, IDLE 1111
- phase_start_out  out  1  one-cycle pulse when a new phase is committed
- round_rst_out  out  1  one-cycle pulse resetting phase modules at each new round
- player_hp_out  out  8  current player HP
- enemy_hp_out  out  8  current enemy HP
- round_count_out  out  8  completed rounds, saturates at 255
- game_over_out  out  1  high in WIN or LOSE
- win_out  out  1  high only in WIN

Behaviour:
- Reset (async, rst_n=0):
  - phase IDLE, state_out=1111, all pulses 0
  - player_hp=PLAYER_HP_MAX, enemy_hp=ENEMY_HP_MAX, round_count=0
  - pending request cleared, timeout counter 0
  - Applies mid-phase with no drain.
- Edge detection: each done input is registered; an event is done & ~done_q. Events not matching the current phase are ignored.
- Pending request: an event computes next_phase and sets a pending flag. On the first new_frame_in strictly after the event cycle:
  - phase <= next_phase, pending cleared
  - phase_start_out pulses in the cycle after that new_frame_in
  - a new_frame_in in the same cycle as the event does not commit it.
- IDLE: the first new_frame_in commits MENU.
- MENU event:
  - FIGHT -> next PLAYER
  - HEAL -> player_hp = min(hp+HEAL_AMOUNT, PLAYER_HP_MAX), applied immediately; next ENEMY
- PLAYER event:
  - enemy_hp = sat(enemy_hp - player_dmg_in), floor 0, applied immediately
  - next WIN if result is 0, else ENEMY
- ENEMY phase:
  - each enemy_hit_in subtracts HIT_DAMAGE, floor 0
  - hp reaching 0 overrides any request to next LOSE
  - timeout counter increments on each new_frame_in while committed in ENEMY
  - enemy_done event or counter==ENEMY_TIMEOUT_FRAMES -> next MENU; round_count+1 and a round_rst_out pulse on commit
  - counter clears on leaving ENEMY
- Same-cycle enemy_done and fatal hit: LOSE.
- enemy_hit_in outside the committed ENEMY phase is ignored, including while a pending exit from ENEMY awaits a frame.
- Once pending is set, later events in that phase are ignored.
- WIN/LOSE: terminal; done and hit inputs ignored.
  - restart_in restores both HPs, zeroes round_count, sets phase IDLE next cycle.
  - restart_in in other phases is ignored.
- All outputs are registered.

Decomposition:
- battle_pkg holds:
  - phase_t enum with the state_out codes above
  - menu choice constants
- Sub-module hp_counter(MAX): saturating add/sub register with load-to-MAX. Instantiated twice, for player and enemy.

Test Plan:
- Reset, then one new_frame -> state_out 0000 and phase_start pulse one cycle later; player_hp=20, enemy_hp=100.
- MENU FIGHT done, then PLAYER done with dmg=30, then frames -> sequence 0000→0001→1000; enemy_hp=70. Each commit lands only after a subsequent new_frame; a same-cycle frame does not commit.
- In ENEMY, 3 hits then enemy_done -> player_hp=8; next frame state_out=0000, round_count=1, round_rst_out pulsed once.
- ENEMY with no done: 600 frames -> MENU on the frame after the count reaches 600. Hits during MENU leave hp unchanged.
- Player_hp=4: a hit and enemy_done in the same cycle -> LOSE (0010), game_over_out=1, win_out=0. restart_in -> IDLE, hp 20/100, round 0.
- PLAYER dmg=255 with enemy_hp=100 -> enemy_hp=0, WIN (0100), win_out=1. rst_n low mid-ENEMY -> immediate IDLE, all outputs at reset values.
